// File: rtl/hazard5_operand_fwd.sv
// hazard5_operand_fwd: X-stage operand forwarding, M/W writeback slots and load-use stall.
// Define HAZARD5_OPERAND_FWD_EN for M/W forwarding; when undefined the block is interlock-only.
module hazard5_operand_fwd #(
  parameter int W_DATA = 32,
  parameter int N_REGS = 32,
  parameter int W_ADDR = $clog2(N_REGS)
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              adv,
  output logic              stall,

  input  logic [W_ADDR-1:0] d_rs1,
  input  logic [W_ADDR-1:0] d_rs2,
  input  logic [W_DATA-1:0] rf_rdata1,
  input  logic [W_DATA-1:0] rf_rdata2,

  input  logic [W_ADDR-1:0] x_rd,
  input  logic              x_rd_wen,
  input  logic              x_is_load,
  input  logic [W_DATA-1:0] x_result,
  input  logic [W_DATA-1:0] m_load_data,

  output logic [W_DATA-1:0] x_op1,
  output logic [W_DATA-1:0] x_op2,
  output logic [W_ADDR-1:0] rf_waddr,
  output logic [W_DATA-1:0] rf_wdata,
  output logic              rf_wen
);

  typedef struct packed {
    logic [W_ADDR-1:0] rd;
    logic              wen;
    logic              is_load;
    logic [W_DATA-1:0] result;
  } m_slot_t;

  typedef struct packed {
    logic [W_ADDR-1:0] rd;
    logic              wen;
    logic [W_DATA-1:0] data;
  } w_slot_t;

  m_slot_t m_q;
  w_slot_t w_q;

  // Writes to x0 are dropped at M entry so no later stage can forward or commit them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q <= '0;
      w_q <= '0;
    end else if (adv) begin
      // NOTE: non-blocking so W captures the M contents from before this edge.
      m_q.rd      <= x_rd;
      m_q.wen     <= x_rd_wen && (|x_rd);
      m_q.is_load <= x_is_load;
      m_q.result  <= x_result;
      w_q.rd      <= m_q.rd;
      w_q.wen     <= m_q.wen;
      w_q.data    <= m_q.is_load ? m_load_data : m_q.result;
    end
  end

  // Gating with adv keeps a held W slot from writing once per stalled cycle.
  assign rf_waddr = w_q.rd;
  assign rf_wdata = w_q.data;
  assign rf_wen   = w_q.wen && adv;

`ifdef HAZARD5_OPERAND_FWD_EN

  logic [W_ADDR-1:0] x_rs1_q;
  logic [W_ADDR-1:0] x_rs2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_rs1_q <= '0;
      x_rs2_q <= '0;
    end else if (adv && !stall) begin
      x_rs1_q <= d_rs1;
      x_rs2_q <= d_rs2;
    end
  end

  // M wins over W; a load in M is never a source because the load-use stall covers it.
  function automatic logic [W_DATA-1:0] fwd_operand(
    input logic [W_ADDR-1:0] rs,
    input logic [W_DATA-1:0] rdata,
    input m_slot_t           m,
    input w_slot_t           w
  );
    if ((|rs) && m.wen && (m.rd == rs) && !m.is_load)
      return m.result;
    if ((|rs) && w.wen && (w.rd == rs))
      return w.data;
    return rdata;
  endfunction

  assign x_op1 = fwd_operand(x_rs1_q, rf_rdata1, m_q, w_q);
  assign x_op2 = fwd_operand(x_rs2_q, rf_rdata2, m_q, w_q);

  assign stall = x_is_load && x_rd_wen && (|x_rd) &&
                 ((x_rd == d_rs1) || (x_rd == d_rs2));

`else

  // Without forwarding, any producer still in X or M must drain to W, where the
  // register file's write-to-read bypass delivers it.
  function automatic logic rs_busy(
    input logic [W_ADDR-1:0] rs,
    input logic [W_ADDR-1:0] xrd,
    input logic              xwen,
    input m_slot_t           m
  );
    return (|rs) && ((xwen && (xrd == rs)) || (m.wen && (m.rd == rs)));
  endfunction

  assign x_op1 = rf_rdata1;
  assign x_op2 = rf_rdata2;

  assign stall = rs_busy(d_rs1, x_rd, x_rd_wen, m_q) ||
                 rs_busy(d_rs2, x_rd, x_rd_wen, m_q);

`endif

endmodule

// File: tb/tb_hazard5_operand_fwd.sv
// Directed bench for hazard5_operand_fwd: driver queues expectations, a negedge monitor checks them.
// Expectations track HAZARD5_OPERAND_FWD_EN: forwarded values when defined, raw register file data otherwise.
module tb_hazard5_operand_fwd;

  localparam int W_DATA = 32;
  localparam int N_REGS = 32;
  localparam int W_ADDR = 5;

`ifdef HAZARD5_OPERAND_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef enum logic [2:0] {SIG_OP1, SIG_OP2, SIG_STALL, SIG_WEN, SIG_WADDR, SIG_WDATA} sig_e;

  typedef struct {
    int          cyc;
    sig_e        sig;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];

  logic              clk = 1'b0;
  logic              rst;
  logic              adv;
  logic              stall;
  logic [W_ADDR-1:0] d_rs1, d_rs2;
  logic [W_DATA-1:0] rf_rdata1, rf_rdata2;
  logic [W_ADDR-1:0] x_rd;
  logic              x_rd_wen, x_is_load;
  logic [W_DATA-1:0] x_result, m_load_data;
  logic [W_DATA-1:0] x_op1, x_op2;
  logic [W_ADDR-1:0] rf_waddr;
  logic [W_DATA-1:0] rf_wdata;
  logic              rf_wen;

  always #5 clk = ~clk;

  hazard5_operand_fwd #(.W_DATA(W_DATA), .N_REGS(N_REGS), .W_ADDR(W_ADDR)) dut (
    .clk(clk), .rst(rst), .adv(adv), .stall(stall),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .x_rd(x_rd), .x_rd_wen(x_rd_wen), .x_is_load(x_is_load), .x_result(x_result),
    .m_load_data(m_load_data),
    .x_op1(x_op1), .x_op2(x_op2), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wen(rf_wen)
  );

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got 0x%08h, want 0x%08h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] sample(input sig_e s);
    case (s)
      SIG_OP1:   return x_op1;
      SIG_OP2:   return x_op2;
      SIG_STALL: return {31'd0, stall};
      SIG_WEN:   return {31'd0, rf_wen};
      SIG_WADDR: return {27'd0, rf_waddr};
      default:   return rf_wdata;
    endcase
  endfunction

  // Monitor: every negedge, compare all expectations queued for this cycle or earlier.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        check(e.name, sample(e.sig), e.exp);
      end
    end
  end

  function automatic logic [31:0] pick(input logic [31:0] fwd_val, input logic [31:0] ilk_val);
    return FWD ? fwd_val : ilk_val;
  endfunction

  task automatic want(input sig_e s, input logic [31:0] v, input string n);
    exp_t e;
    e.cyc = cyc; e.sig = s; e.exp = v; e.name = n;
    sb.push_back(e);
  endtask

  task automatic idle();
    adv = 1'b1; d_rs1 = '0; d_rs2 = '0; rf_rdata1 = '0; rf_rdata2 = '0;
    x_rd = '0; x_rd_wen = 1'b0; x_is_load = 1'b0; x_result = '0; m_load_data = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    idle();
  endtask

  task automatic drv_x(input logic [4:0] rd, input logic wen, input logic ld, input logic [31:0] res);
    x_rd = rd; x_rd_wen = wen; x_is_load = ld; x_result = res;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // c0: reset state, operands straight from the register file
    rf_rdata1 = 32'h1234; rf_rdata2 = 32'h5678;
    want(SIG_OP1, 32'h1234, "reset_op1");
    want(SIG_OP2, 32'h5678, "reset_op2");
    want(SIG_STALL, 0, "reset_stall");
    want(SIG_WEN, 0, "reset_rf_wen");
    want(SIG_WADDR, 0, "reset_rf_waddr");
    want(SIG_WDATA, 0, "reset_rf_wdata");

    // Back-to-back RAW on x5
    step(); drv_x(5'd5, 1, 0, 32'h11); d_rs1 = 5'd5;
    want(SIG_STALL, pick(0, 1), "b2b_stall_x");
    step(); d_rs1 = 5'd5; rf_rdata1 = 32'hBAD1;
    want(SIG_OP1, pick(32'h11, 32'hBAD1), "b2b_op1_from_m");
    want(SIG_STALL, pick(0, 1), "b2b_stall_m");
    step(); rf_rdata1 = 32'hBAD1;
    want(SIG_OP1, pick(32'h11, 32'hBAD1), "b2b_op1_from_w");
    want(SIG_STALL, 0, "b2b_stall_clear");
    want(SIG_WEN, 1, "b2b_rf_wen");
    want(SIG_WADDR, 5, "b2b_rf_waddr");
    want(SIG_WDATA, 32'h11, "b2b_rf_wdata");
    step();
    want(SIG_WEN, 0, "b2b_single_write");

    // Two-behind RAW on x7 via rs2, with x8 in between
    step(); drv_x(5'd7, 1, 0, 32'hA5);
    step(); drv_x(5'd8, 1, 0, 32'h88); d_rs2 = 5'd7;
    want(SIG_STALL, pick(0, 1), "two_stall");
    step(); rf_rdata2 = 32'hBAD2;
    want(SIG_OP2, pick(32'hA5, 32'hBAD2), "two_op2_from_w");
    want(SIG_WEN, 1, "two_rf_wen");
    want(SIG_WADDR, 7, "two_rf_waddr");
    want(SIG_WDATA, 32'hA5, "two_rf_wdata");
    step();
    want(SIG_WADDR, 8, "two_next_waddr");
    want(SIG_WDATA, 32'h88, "two_next_wdata");

    // M beats W on x3
    step(); drv_x(5'd3, 1, 0, 32'd1);
    step(); drv_x(5'd3, 1, 0, 32'd2); d_rs1 = 5'd3;
    want(SIG_STALL, pick(0, 1), "prio_stall");
    step(); rf_rdata1 = 32'hBAD3;
    want(SIG_OP1, pick(32'd2, 32'hBAD3), "prio_op1_m_wins");
    want(SIG_WADDR, 3, "prio_rf_waddr");
    want(SIG_WDATA, 32'd1, "prio_rf_wdata_old");
    step();
    want(SIG_WDATA, 32'd2, "prio_rf_wdata_new");

    // Load-use on x9 through rs2
    step(); drv_x(5'd9, 1, 1, 32'h1000); d_rs2 = 5'd9;
    want(SIG_STALL, 1, "lu_stall");
    step(); d_rs2 = 5'd9; m_load_data = 32'hDEADBEEF;
    want(SIG_STALL, pick(0, 1), "lu_stall_after");
    step(); rf_rdata2 = 32'hBAD4;
    want(SIG_OP2, pick(32'hDEADBEEF, 32'hBAD4), "lu_op2_from_w");
    want(SIG_WEN, 1, "lu_rf_wen");
    want(SIG_WADDR, 9, "lu_rf_waddr");
    want(SIG_WDATA, 32'hDEADBEEF, "lu_rf_wdata");

    // Write to x0 is dropped
    step(); drv_x(5'd0, 1, 0, 32'h77);
    want(SIG_STALL, 0, "x0_stall");
    step();
    want(SIG_OP1, 0, "x0_op1");
    want(SIG_WEN, 0, "x0_rf_wen_m");
    step();
    want(SIG_WEN, 0, "x0_rf_wen_w");

    // Bus stall with x4 held in W
    step(); drv_x(5'd4, 1, 0, 32'h44);
    step(); d_rs1 = 5'd4;
    want(SIG_STALL, pick(0, 1), "bus_stall_m");
    step(); adv = 1'b0; rf_rdata1 = 32'hBAD5;
    want(SIG_OP1, pick(32'h44, 32'hBAD5), "bus_op1_held");
    want(SIG_WEN, 0, "bus_rf_wen_0");
    want(SIG_WADDR, 4, "bus_rf_waddr_held");
    step(); adv = 1'b0;
    want(SIG_WEN, 0, "bus_rf_wen_1");
    step(); adv = 1'b0; rf_rdata1 = 32'hBAD5;
    want(SIG_WEN, 0, "bus_rf_wen_2");
    want(SIG_OP1, pick(32'h44, 32'hBAD5), "bus_op1_still");
    step();
    want(SIG_WEN, 1, "bus_rf_wen_resume");
    want(SIG_WADDR, 4, "bus_rf_waddr");
    want(SIG_WDATA, 32'h44, "bus_rf_wdata");
    step();
    want(SIG_WEN, 0, "bus_single_write");

    // Reset mid-flight with x10 in W and x11 in M
    step(); drv_x(5'd10, 1, 0, 32'hAA);
    step(); drv_x(5'd11, 1, 0, 32'hBB); d_rs1 = 5'd10; d_rs2 = 5'd11;
    want(SIG_STALL, pick(0, 1), "rst_pre_stall");
    step(); rf_rdata1 = 32'hC1; rf_rdata2 = 32'hC2;
    want(SIG_OP1, pick(32'hAA, 32'hC1), "rst_pre_op1");
    want(SIG_OP2, pick(32'hBB, 32'hC2), "rst_pre_op2");
    want(SIG_WADDR, 10, "rst_pre_waddr");
    @(negedge clk);
    #1 rst = 1'b1;
    step();
    rst = 1'b0;
    d_rs1 = 5'd10; d_rs2 = 5'd11;
    want(SIG_WEN, 0, "rst_rf_wen");
    want(SIG_WADDR, 0, "rst_rf_waddr");
    want(SIG_WDATA, 0, "rst_rf_wdata");
    want(SIG_STALL, 0, "rst_stall");
    step(); rf_rdata1 = 32'hD1; rf_rdata2 = 32'hD2;
    want(SIG_OP1, 32'hD1, "rst_post_op1");
    want(SIG_OP2, 32'hD2, "rst_post_op2");
    want(SIG_WEN, 0, "rst_post_rf_wen");

    repeat (3) step();
    check("scoreboard_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard5_operand_fwd.md
# hazard5_operand_fwd

Operand forwarding and writeback pipeline for the Hazard5 core. It sits on both sides of the 1-write/2-read register file:
- downstream of the read port: it takes the registered read data and corrects it with in-flight results, producing the X-stage operands;
- upstream of the write port: it carries X-stage results through the M and W slots and drives the register file write.

It also detects load-use hazards and requests a one-cycle decode stall.

## Interface
- `W_DATA`, 32, data width.
- `N_REGS`, 32, register count.
- `W_ADDR`, `$clog2(N_REGS)`, register address width.

Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous active-high reset.

Pipeline control:
- `adv`  in  1  global pipeline advance (low on bus stall).
- `stall`  out  1  load-use hazard: freeze D, inject X bubble.

Decode and register file read side:
- `d_rs1`, `d_rs2`  in  W_ADDR  D-stage source addresses (same as register file read addresses).
- `rf_rdata1`, `rf_rdata2`  in  W_DATA  register file read data, valid in X.

X and M results:
- `x_rd`  in  W_ADDR  X-stage destination.
- `x_rd_wen`  in  1  X-stage writes `x_rd`.
- `x_is_load`  in  1  X-stage instruction is a load.
- `x_result`  in  W_DATA  X-stage ALU result.
- `m_load_data`  in  W_DATA  load data, valid when M completes.

Outputs:
- `x_op1`, `x_op2`  out  W_DATA  forwarded X-stage operands.
- `rf_waddr`  out  W_ADDR  register file write address.
- `rf_wdata`  out  W_DATA  register file write data.
- `rf_wen`  out  1  register file write enable.

## Operation
- Register file read enable is required to be `adv & !stall`, driven by the core.
- X address latch: on `adv & !stall`, capture `d_rs1` and `d_rs2` into `x_rs1_q` and `x_rs2_q`; otherwise hold.
- M slot (`rd`, `wen`, `is_load`, `result`):
  - on `adv`, capture the X inputs;
  - `wen` is captured as `x_rd_wen & |x_rd`, so writes to x0 are dropped.
- W slot (`rd`, `wen`, `data`):
  - on `adv`, capture the M slot;
  - `data` = M `is_load` ? `m_load_data` : M `result`.
- Write port: `rf_waddr` = W `rd`, `rf_wdata` = W `data`, `rf_wen` = W `wen & adv`. Each result is written exactly once.
- Forwarding, per operand with `rs` = `x_rsN_q`:
  - if `rs != 0` and M `wen` and M `rd == rs` and not M `is_load`: use M `result`;
  - else if `rs != 0` and W `wen` and W `rd == rs`: use W `data`;
  - else use `rf_rdataN`.
- M beats W when both match.
- Producers three or more instructions ahead reach the consumer through the register file's own write-to-read bypass; this block does not handle them.
- Load-use stall: `stall` = X load with `x_rd_wen`, `x_rd != 0`, and `x_rd` equal to `d_rs1` or `d_rs2`.
  - `stall` is combinational and independent of `adv`.
  - The core guarantees an X bubble (`x_rd_wen = 0`) in the cycle after `adv & stall`.
- A load in M never matches a consumer in X, because the stall prevents it.

## Timing
- Reset: all slot and latch registers are cleared to 0. `rf_wen`=0, `rf_waddr`=0, `rf_wdata`=0.
- After reset, `x_op1`/`x_op2` equal `rf_rdata1`/`rf_rdata2` (0 from a reset register file).
- Latency: a result is forwardable to X one cycle after it leaves X (M slot) and two cycles after (W slot). Its register file write occurs on the `adv` edge that retires W.
- Operand and stall paths are combinational: no clock edge lies between an address match and `x_opN` or `stall`.
- `adv`=0: all slots hold and forwarding continues from the held slots. `rf_wen`=0, so there are no duplicate writes.
- Reset asserted mid-operation: in-flight results are discarded with no register file write. `stall` deasserts once the X inputs go idle.

## Configuration
- `HAZARD5_OPERAND_FWD_EN` defined: full M and W forwarding as above; `stall` asserts on load-use only.
- Undefined, interlock-only mode:
  - `x_opN = rf_rdataN` always, and the mux logic is removed.
  - `stall` asserts when a nonzero `d_rs1`/`d_rs2` matches `x_rd` (with `x_rd_wen`) or M `rd` (with M `wen`), regardless of load.
  - The M and W slots and the write port are unchanged.

## Test plan
- **Back-to-back RAW:** X `addi x5`, `x_result`=0x11, then consumer with `rs1`=x5 → `x_op1`=0x11 from M. With FWD off, `stall`=1 for 2 cycles.
- **Two-behind RAW:** producer writes x7=0xA5; consumer two instructions later → `x_op2`=0xA5 from W, and `rf_wen`=1, `rf_waddr`=7 on the same edge.
- **M/W priority:** x3=1 in W, x3=2 in M, consumer reads x3 → `x_op1`=2.
- **Load-use:** load x9 in X, D `rs2`=x9 → `stall`=1 for one cycle. Then `m_load_data`=0xDEADBEEF reaches the consumer via W; `x_op2`=0xDEADBEEF.
- **x0 and bus stall:** write to x0 → `rf_wen` never asserts and `x_op1` is never forwarded. With `adv`=0 for 3 cycles and W holding x4 → a single write after `adv` returns.
- **Reset mid-flight:** results valid in M and W, `rst` pulsed → `rf_wen` stays 0 and the next consumer sees `rf_rdata`.
